wboled_fifo: RTL and testbench

- Second-generation Wishbone controller for SPI-driven OLED panels (SSD1306/SSD1331 class).
- Bus writes queue command and data bytes in a parametrised FIFO, so the CPU or DMA no longer sees writes dropped while the panel is busy.
- An internal serializer drives SCK/MOSI/CSn/DC with a parametrised clock divider.
- Adds sticky overflow status, a fill-level interrupt threshold, FIFO flush, and interlocked power-rail control.

---
 rtl/wboled_fifo_if.sv | 15 +
 rtl/wboled_fifo.sv | 197 +++++++++++++++++++
 tb/tb_wboled_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wboled_fifo_if.sv
// Wishbone slave bus bundle for the OLED FIFO controller.
// The master drives the request and write data; the slave returns ack, stall and read data.
interface wboled_fifo_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;

    modport master (output cyc, stb, we, addr, wdata, input ack, stall, rdata);
    modport slave  (input cyc, stb, we, addr, wdata, output ack, stall, rdata);
endinterface

// File: rtl/wboled_fifo.sv
// Wishbone OLED controller: bus writes queue command/pixel entries in a FIFO,
// and a serializer shifts each entry out over SPI inside its own CSn frame.
// Also provides sticky overflow, a fill-level interrupt, flush and power-rail control.
module wboled_fifo #(
    parameter int LGFIFO = 5,
    parameter int DIV    = 4,
    parameter int GAP    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    wboled_fifo_if.slave  wb,
    output logic          o_sck,
    output logic          o_mosi,
    output logic          o_csn,
    output logic          o_dbit,
    output logic [2:0]    o_pwr,
    output logic          o_int
);
    localparam int DEPTH = 1 << LGFIFO;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_GAP} state_t;

    state_t            state;
    logic [17:0]       mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   fill;
    logic [12:0]       fill_ext;
    logic              overflow;
    logic [12:0]       thresh;
    logic              req, wr, ctrl_wr, flush, push_req, push_ok, pop, full, empty, busy;
    logic [17:0]       push_entry, head;
    logic [2:0]        pwr_next;
    logic [31:0]       rd_mux;
    logic [15:0]       shreg;
    logic [4:0]        nbits;
    logic [7:0]        timer;
    logic              unused_bits;

    assign req      = wb.cyc && wb.stb;
    assign wr       = req && wb.we;
    assign ctrl_wr  = wr && (wb.addr == 2'd0);
    assign flush    = ctrl_wr && wb.wdata[31];
    assign push_req = wr && ((wb.addr == 2'd1) || (wb.addr == 2'd2));
    assign full     = (fill == (LGFIFO+1)'(DEPTH));
    assign empty    = (fill == '0);
    assign busy     = (state != S_IDLE);
    assign pop      = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop) && !flush;
    assign head     = mem[rd_ptr];
    assign fill_ext = {{(12-LGFIFO){1'b0}}, fill};
    assign wb.stall = 1'b0;
    assign unused_bits = ^wb.wdata[29:19];

    // Build the FIFO entry, the next power state and the read mux.
    always_comb begin
        push_entry = {1'b0, wb.wdata[16], wb.wdata[15:0]};
        if (wb.addr == 2'd2)
            push_entry = {1'b1, 1'b1, wb.wdata[15:0]};
        pwr_next = (o_pwr & ~wb.wdata[18:16]) | (wb.wdata[2:0] & wb.wdata[18:16]);
        // VCC may only be enabled while the module rail is on.
        if (!pwr_next[0])
            pwr_next[1] = 1'b0;
        case (wb.addr)
            2'd0:    rd_mux = {overflow, 2'b00, fill_ext, 8'h00, full, empty, busy, 2'b00, o_pwr};
            2'd3:    rd_mux = {19'h0, thresh};
            default: rd_mux = 32'h0;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers, fill level and sticky overflow; flush takes priority over push/pop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop})
                    2'b10:   fill <= fill + 1'b1;
                    2'b01:   fill <= fill - 1'b1;
                    default: fill <= fill;
                endcase
            end
            if (ctrl_wr && wb.wdata[30])
                overflow <= 1'b0;
            else if (push_req && !flush && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Bus acknowledge, read data, control registers and the level interrupt.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wb.ack   <= 1'b0;
            wb.rdata <= 32'h0;
            o_pwr    <= 3'b000;
            thresh   <= 13'h0;
            o_int    <= 1'b0;
        end else begin
            wb.ack <= req;
            if (req)
                wb.rdata <= rd_mux;
            if (ctrl_wr)
                o_pwr <= pwr_next;
            if (wr && (wb.addr == 2'd3))
                thresh <= wb.wdata[12:0];
            o_int <= (fill_ext <= thresh) && !overflow;
        end
    end

    // Serializer: one CSn frame per entry, SCK idles high, MOSI changes on the falling edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            o_sck  <= 1'b1;
            o_mosi <= 1'b0;
            o_csn  <= 1'b1;
            o_dbit <= 1'b0;
            shreg  <= 16'h0;
            nbits  <= 5'd0;
            timer  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg  <= head[16] ? head[15:0] : {head[7:0], 8'h00};
                        nbits  <= head[16] ? 5'd16 : 5'd8;
                        o_dbit <= head[17];
                        o_csn  <= 1'b0;
                        timer  <= 8'(DIV - 1);
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (timer == 8'd0) begin
                        o_sck  <= 1'b0;
                        o_mosi <= shreg[15];
                        timer  <= 8'(DIV - 1);
                        state  <= S_LOW;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_LOW: begin
                    if (timer == 8'd0) begin
                        o_sck <= 1'b1;
                        timer <= 8'(DIV - 1);
                        state <= S_HIGH;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (timer == 8'd0) begin
                        shreg <= {shreg[14:0], 1'b0};
                        nbits <= nbits - 1'b1;
                        if (nbits == 5'd1) begin
                            o_csn <= 1'b1;
                            timer <= 8'(GAP - 1);
                            state <= S_GAP;
                        end else begin
                            o_sck  <= 1'b0;
                            o_mosi <= shreg[14];
                            timer  <= 8'(DIV - 1);
                            state  <= S_LOW;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == 8'd0)
                        state <= S_IDLE;
                    else
                        timer <= timer - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wboled_fifo.sv
// Directed bench for wboled_fifo (LGFIFO=2, DIV=4, GAP=2): bus handshake, SPI frames,
// overflow, flush, power interlock and the fill-level interrupt.
module tb_wboled_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck, mosi, csn, dbit, intr;
    logic [2:0] pwr;
    logic [31:0] rd;
    bit          ok;

    wboled_fifo_if bus ();

    wboled_fifo #(.LGFIFO(2), .DIV(4), .GAP(2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .wb        (bus),
        .o_sck     (sck),
        .o_mosi    (mosi),
        .o_csn     (csn),
        .o_dbit    (dbit),
        .o_pwr     (pwr),
        .o_int     (intr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SPI frame monitor, sampled on the falling system-clock edge.
    logic [15:0] fr_data [16];
    int          fr_n    [16];
    int          fr_low  [16];
    int          fr_gap  [16];
    logic        fr_dc   [16];
    int          nfr = 0;
    int          dbit_bad = 0;

    initial begin
        logic        prev_csn, prev_sck, cur_dc;
        logic [15:0] sh;
        int          nb, lowc, highc, gap_at_fall;
        prev_csn = 1'b1; prev_sck = 1'b1; cur_dc = 1'b0;
        sh = 16'h0; nb = 0; lowc = 0; highc = 0; gap_at_fall = 0;
        forever begin
            @(negedge clk);
            if (prev_csn && !csn) begin
                sh = 16'h0; nb = 0; lowc = 0; cur_dc = dbit; gap_at_fall = highc;
            end
            if (!csn) begin
                lowc++;
                if (!prev_sck && sck) begin
                    sh = {sh[14:0], mosi};
                    nb++;
                end
                if (dbit !== cur_dc) dbit_bad++;
            end else begin
                highc = prev_csn ? highc + 1 : 1;
            end
            if (!prev_csn && csn && nfr < 16) begin
                fr_data[nfr] = sh; fr_n[nfr] = nb; fr_low[nfr] = lowc;
                fr_gap[nfr] = gap_at_fall; fr_dc[nfr] = cur_dc;
                nfr++;
            end
            prev_csn = csn;
            prev_sck = sck;
        end
    end

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        check("ack_wr", bus.ack, 1);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = 32'h0;
        @(posedge clk); #1;
        check("ack_rd", bus.ack, 1);
        d = bus.rdata;
        bus.cyc = 1'b0; bus.stb = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000 && nfr < target; i++) @(negedge clk);
        @(negedge clk);
        check("frame_count", nfr, target);
    endtask

    task automatic wait_csn_fall(output bit found);
        logic p;
        p = csn;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (p && !csn) begin
                found = 1'b1;
                break;
            end
            p = csn;
        end
    endtask

    task automatic check_frame(input int idx, input int n, input logic [15:0] data,
                               input logic dc, input int low);
        check($sformatf("f%0d_bits", idx), fr_n[idx], n);
        check($sformatf("f%0d_data", idx), fr_data[idx], data);
        check($sformatf("f%0d_dc", idx), fr_dc[idx], dc);
        check($sformatf("f%0d_low", idx), fr_low[idx], low);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", csn, 1);
        check("rst_sck", sck, 1);
        check("rst_mosi", mosi, 0);
        check("rst_dbit", dbit, 0);
        check("rst_pwr", pwr, 3'b000);
        check("rst_int", intr, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("stall", bus.stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("int_after_rst", intr, 1);
        repeat (9) @(posedge clk);
        #1;
        check("idle_csn", csn, 1);
        check("idle_sck", sck, 1);
        check("idle_pwr", pwr, 3'b000);
        wb_read(2'd0, rd);
        check("status_reset", rd, 32'h0000_0040);
        @(posedge clk); #1;
        check("ack_drop", bus.ack, 0);

        // Single 8-bit command
        wb_write(2'd1, 32'h0000_00AF);
        wait_frames(1);
        check_frame(0, 8, 16'h00AF, 1'b0, 68);

        // Pixel then 16-bit command back-to-back
        repeat (10) @(posedge clk);
        #1;
        wb_write(2'd2, 32'h0000_1234);
        wb_write(2'd1, 32'h0001_8100);
        wait_frames(3);
        check_frame(1, 16, 16'h1234, 1'b1, 132);
        check_frame(2, 16, 16'h8100, 1'b0, 132);
        check("f2_gap", fr_gap[2], 3);

        // Overflow with a 4-deep FIFO, then clear, then flush mid-transfer
        repeat (10) @(posedge clk);
        #1;
        for (int i = 1; i <= 6; i++) wb_write(2'd2, 32'h0000_A000 + i);
        wb_read(2'd0, rd);
        check("status_ovf", rd, 32'h8004_00A0);
        wb_write(2'd0, 32'h4000_0000);
        wb_read(2'd0, rd);
        check("status_ovf_clr", rd, 32'h0004_00A0);
        wb_write(2'd0, 32'h8000_0000);
        wb_read(2'd0, rd);
        check("status_flushed", rd, 32'h0000_0060);
        wait_frames(4);
        check_frame(3, 16, 16'hA001, 1'b1, 132);
        repeat (300) @(posedge clk);
        #1;
        check("no_frames_after_flush", nfr, 4);

        // Power-rail masks and interlock
        wb_write(2'd0, 32'h0003_0002);
        check("pwr_interlock", pwr, 3'b000);
        wb_write(2'd0, 32'h0001_0001);
        check("pwr_pmod", pwr, 3'b001);
        wb_write(2'd0, 32'h0002_0002);
        check("pwr_vcc", pwr, 3'b011);
        wb_read(2'd0, rd);
        check("status_pwr", rd, 32'h0000_0043);
        wb_write(2'd0, 32'h0001_0000);
        check("pwr_off", pwr, 3'b000);

        // Threshold interrupt
        wb_write(2'd3, 32'h0000_0002);
        wb_read(2'd3, rd);
        check("thresh_rd", rd, 32'h0000_0002);
        check("int_idle", intr, 1);
        for (int i = 1; i <= 5; i++) wb_write(2'd2, 32'h0000_B000 + i);
        check("int_busy", intr, 0);
        wait_csn_fall(ok);
        check("csn_fall_a", ok, 1);
        wait_csn_fall(ok);
        check("csn_fall_b", ok, 1);
        check("int_at_pop", intr, 0);
        @(posedge clk); #1;
        check("int_rise", intr, 1);
        wait_frames(9);
        check_frame(8, 16, 16'hB005, 1'b1, 132);
        check("dbit_stable", dbit_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
